// File: rtl/contador_crescente_pkg.sv
// Shared types and BCD helpers for the two-digit up counter.
package contador_crescente_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } estado_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Saturate a single digit into the legal BCD range.
  function automatic bcd_t clamp_digit(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : bcd_t'(d);
  endfunction

  // Clamp both digits of a two-digit BCD value.
  function automatic logic [7:0] clamp_bcd2(input logic [7:0] v);
    return {clamp_digit(v[7:4]), clamp_digit(v[3:0])};
  endfunction

  // Two-digit BCD increment; ones 9 -> 0 with carry, tens 9 -> 0.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    bcd_t tens;
    bcd_t ones;
    tens = v[7:4];
    ones = v[3:0];
    if (ones >= BCD_MAX) begin
      ones = 4'd0;
      tens = (tens >= BCD_MAX) ? 4'd0 : tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/contador_crescente_sinc_borda.sv
// Button synchronizer and rising-edge detector.
// The edge output is held off after reset until the synchronized button has
// been seen low, so a button held through reset release never starts a count.
module sinc_borda (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic pulse
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic [1:0] fill_q;   // marks when sync2_q holds a real sample
  logic       armed_q;
  logic       armed_d;

  // Arm once the synchronizer output is valid and low.
  always_comb begin
    armed_d = armed_q | (fill_q[1] & ~sync2_q);
  end

  // Synchronizer chain, edge history and arming state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_d;
    end
  end

  assign pulse = armed_q & sync2_q & ~prev_q;

endmodule

// File: rtl/contador_crescente.sv
// Two-digit BCD up counter with start/pause button and programmable limit.
module contador_crescente
  import contador_crescente_pkg::*;
#(
  parameter bit AUTO_RESTART = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       button,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic [7:0] Q,
  output logic       terminal,
  output logic       running
);

  estado_t    state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] lim_q, lim_d;
  logic       term_q, term_d;
  logic       start;

  sinc_borda u_sinc (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (button),
    .pulse   (start)
  );

  // Next-state, count and terminal decode; start beats enable in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    term_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'h00;
        if (start) begin
          lim_d   = clamp_bcd2(limit);
          state_d = RUN;
        end
      end
      RUN: begin
        if (start) begin
          state_d = PAUSE;
        end else if (enable) begin
          if (cnt_q == lim_q) begin
            term_d = 1'b1;
            if (AUTO_RESTART) cnt_d = 8'h00;
            else              state_d = DONE;
          end else begin
            cnt_d = bcd_inc(cnt_q);
          end
        end
      end
      PAUSE: begin
        if (start) state_d = RUN;
      end
      DONE: begin
        if (start) begin
          cnt_d   = 8'h00;
          lim_d   = clamp_bcd2(limit);
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'h00;
      end
    endcase
  end

  // State, count, latched limit and registered terminal pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'h00;
      lim_q   <= 8'h00;
      term_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      term_q  <= term_d;
    end
  end

  assign Q        = cnt_q;
  assign terminal = term_q;
  assign running  = (state_q == RUN);

endmodule
